// File: rtl/traffic_pkg.sv
// Shared light codes and debounce state encoding for the traffic controller
// and its side-road sensor conditioner.
package traffic_pkg;

   localparam logic [1:0] MAIN_GREEN  = 2'b00;
   localparam logic [1:0] MAIN_YELLOW = 2'b01;
   localparam logic [1:0] SIDE_GREEN  = 2'b10;
   localparam logic [1:0] SIDE_YELLOW = 2'b11;

   typedef enum logic [1:0] {
      LOW      = 2'b00,
      RISE_CHK = 2'b01,
      HIGH     = 2'b10,
      FALL_CHK = 2'b11
   } deb_state_t;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/vehicle_sensor_conditioner_if.sv
// Detector-side bundle of the sensor conditioner: raw detector and light
// readback in, clean request, arrival pulse, vehicle count and debug state out.
interface vehicle_sensor_conditioner_if #(
   parameter int CNT_W = 4
);

   logic                    raw_det;
   logic [1:0]              light;
   logic                    sensor;
   logic                    arrival_pulse;
   logic [CNT_W-1:0]        pending_count;
   logic                    fault;
   logic                    det_level;
   traffic_pkg::deb_state_t deb_state;

   // No handshake: every signal is a level sampled at each rising clk edge.
   modport master (
      output raw_det, light,
      input  sensor, arrival_pulse, pending_count, fault, det_level, deb_state
   );

   modport slave (
      input  raw_det, light,
      output sensor, arrival_pulse, pending_count, fault, det_level, deb_state
   );

endinterface

// File: rtl/sensor_debounce.sv
// Synchronises the raw loop-detector level, debounces it with a four-state FSM
// and flags a detector that stays high for too long.
module sensor_debounce
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int STUCK_CYCLES    = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       raw_det_i,
   output logic       rise_pulse_o,
   output logic       level_o,
   output logic       fault_o,
   output logic       fault_next_o,
   output deb_state_t state_o
);

   localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
   localparam int ST_W = cnt_width(STUCK_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STUCK_CYCLES);

   logic            sync1_q, sync2_q;
   deb_state_t      state_q, state_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic [ST_W-1:0] stuck_q, stuck_d;
   logic            fault_q, fault_d;
   logic            rise;
   logic            det_s;
   logic            in_high;

   assign det_s   = sync2_q;
   assign in_high = (state_q == HIGH) || (state_q == FALL_CHK);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         state_q  <= LOW;
         db_cnt_q <= '0;
         stuck_q  <= '0;
         fault_q  <= 1'b0;
      end else begin
         sync1_q  <= raw_det_i;
         sync2_q  <= sync1_q;
         state_q  <= state_d;
         db_cnt_q <= db_cnt_d;
         stuck_q  <= stuck_d;
         fault_q  <= fault_d;
      end
   end

   // The sample that leaves LOW/HIGH is the first of the stable run.
   always_comb begin
      state_d  = state_q;
      db_cnt_d = db_cnt_q;
      rise     = 1'b0;
      case (state_q)
         LOW: begin
            if (det_s) begin
               if (db_cnt_q == DB_LAST) begin
                  state_d  = HIGH;
                  db_cnt_d = '0;
                  rise     = 1'b1;
               end else begin
                  state_d  = RISE_CHK;
                  db_cnt_d = db_cnt_q + 1'b1;
               end
            end
         end
         RISE_CHK: begin
            if (!det_s) begin
               state_d  = LOW;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d  = HIGH;
               db_cnt_d = '0;
               rise     = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         HIGH: begin
            if (!det_s) begin
               if (db_cnt_q == DB_LAST) begin
                  state_d  = LOW;
                  db_cnt_d = '0;
               end else begin
                  state_d  = FALL_CHK;
                  db_cnt_d = db_cnt_q + 1'b1;
               end
            end
         end
         FALL_CHK: begin
            if (det_s) begin
               state_d  = HIGH;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d  = LOW;
               db_cnt_d = '0;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d  = LOW;
            db_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      stuck_d = '0;
      if (in_high) begin
         stuck_d = (stuck_q == ST_MAX) ? stuck_q : stuck_q + 1'b1;
      end
      fault_d = (state_d == LOW) ? 1'b0 : (fault_q || (stuck_d == ST_MAX));
   end

   assign rise_pulse_o = rise;
   assign level_o      = in_high;
   assign fault_o      = fault_q;
   assign fault_next_o = fault_d;
   assign state_o      = state_q;

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Counts debounced side-road arrivals, retires one per SERVE_CYCLES of side
// green and holds a registered request to the controller while any are waiting.
module vehicle_sensor_conditioner
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SERVE_CYCLES    = 8,
   parameter int STUCK_CYCLES    = 255,
   parameter int CNT_W           = 4
) (
   input logic                         clk,
   input logic                         rst_n,
   vehicle_sensor_conditioner_if.slave bus
);

   localparam int SRV_W = cnt_width(SERVE_CYCLES - 1);
   localparam logic [SRV_W-1:0] SRV_LAST = SRV_W'(SERVE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   logic             rise;
   logic             fault_next;
   logic             retire;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic [SRV_W-1:0] serve_q, serve_d;
   logic             sensor_q, sensor_d;
   logic             arrival_q;

   sensor_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
   ) u_debounce (
      .clk          (clk),
      .rst_n        (rst_n),
      .raw_det_i    (bus.raw_det),
      .rise_pulse_o (rise),
      .level_o      (bus.det_level),
      .fault_o      (bus.fault),
      .fault_next_o (fault_next),
      .state_o      (bus.deb_state)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_q <= '0;
         serve_q   <= '0;
         sensor_q  <= 1'b0;
         arrival_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
         serve_q   <= serve_d;
         sensor_q  <= sensor_d;
         arrival_q <= rise;
      end
   end

   // Any break in side green (or an empty queue) restarts the service window.
   always_comb begin
      serve_d = '0;
      retire  = 1'b0;
      if ((bus.light == SIDE_GREEN) && (pending_q != '0)) begin
         if (serve_q == SRV_LAST) begin
            retire = 1'b1;
         end else begin
            serve_d = serve_q + 1'b1;
         end
      end

      pending_d = pending_q;
      if (rise && !retire) begin
         if (pending_q != PEND_MAX) begin
            pending_d = pending_q + 1'b1;
         end
      end else if (retire && !rise) begin
         pending_d = pending_q - 1'b1;
      end

      sensor_d = (pending_d != '0) || fault_next;
   end

   assign bus.sensor        = sensor_q;
   assign bus.arrival_pulse = arrival_q;
   assign bus.pending_count = pending_q;

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Bench for vehicle_sensor_conditioner: table-driven arrival/service steps,
// hand-written corner sequences and an arrival-time scoreboard.
module tb_vehicle_sensor_conditioner;
   import traffic_pkg::*;

   localparam int DEB   = 4;
   localparam int SERVE = 8;
   localparam int STUCK = 255;
   localparam int CNT_W = 4;

   typedef struct {
      string      name;
      logic       raw;
      logic [1:0] light;
      int         hold;
      logic       arrive;
      logic [3:0] exp_pend;
      logic       exp_sensor;
   } vec_t;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   vehicle_sensor_conditioner_if #(.CNT_W(CNT_W)) bus();

   vehicle_sensor_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .SERVE_CYCLES    (SERVE),
      .STUCK_CYCLES    (STUCK),
      .CNT_W           (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          n_pulses = 0;
   logic [31:0] exp_q[$];
   vec_t        vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One or more clock edges; outputs sampled 1 ns after each edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.arrival_pulse === 1'b1) begin
            n_pulses++;
            if (exp_q.size() == 0) check("arrival_pulse_unexpected", bus.arrival_pulse, 1'b0);
            else check("arrival_time", cyc, exp_q.pop_front());
         end
      end
   endtask

   // A clean rise driven now is accepted DEB+2 edges later.
   task automatic drive(input logic raw, input logic [1:0] lt, input logic arrive);
      bus.raw_det = raw;
      bus.light   = lt;
      if (arrive) exp_q.push_back(cyc + 2 + DEB);
   endtask

   task automatic check_outs(input string tag, input logic [3:0] pend, input logic sens,
                             input logic flt);
      check({tag, "_pending"}, bus.pending_count, pend);
      check({tag, "_sensor"}, bus.sensor, sens);
      check({tag, "_fault"}, bus.fault, flt);
   endtask

   function automatic vec_t mk(input string name, input logic raw, input logic [1:0] lt,
                               input int hold, input logic arrive, input logic [3:0] pend,
                               input logic sens);
      vec_t v;
      v.name = name; v.raw = raw; v.light = lt; v.hold = hold;
      v.arrive = arrive; v.exp_pend = pend; v.exp_sensor = sens;
      return v;
   endfunction

   initial begin
      int base;
      rst_n       = 1'b0;
      bus.raw_det = 1'b1;
      bus.light   = SIDE_GREEN;

      vecs.push_back(mk("arr_before",   1'b1, MAIN_GREEN, 4, 1'b1, 4'd0, 1'b0));
      vecs.push_back(mk("arr_accepted", 1'b1, MAIN_GREEN, 2, 1'b0, 4'd1, 1'b1));
      vecs.push_back(mk("arr_release",  1'b0, MAIN_GREEN, 8, 1'b0, 4'd1, 1'b1));
      vecs.push_back(mk("serve_7",      1'b0, SIDE_GREEN, 7, 1'b0, 4'd1, 1'b1));
      vecs.push_back(mk("serve_8",      1'b0, SIDE_GREEN, 1, 1'b0, 4'd0, 1'b0));
      vecs.push_back(mk("arr2",         1'b1, MAIN_GREEN, 8, 1'b1, 4'd1, 1'b1));
      vecs.push_back(mk("arr2_release", 1'b0, MAIN_GREEN, 8, 1'b0, 4'd1, 1'b1));
      vecs.push_back(mk("part_side_a",  1'b0, SIDE_GREEN, 7, 1'b0, 4'd1, 1'b1));
      vecs.push_back(mk("part_main",    1'b0, MAIN_GREEN, 1, 1'b0, 4'd1, 1'b1));
      vecs.push_back(mk("part_side_b",  1'b0, SIDE_GREEN, 7, 1'b0, 4'd1, 1'b1));
      vecs.push_back(mk("part_side_c",  1'b0, SIDE_GREEN, 1, 1'b0, 4'd0, 1'b0));

      // reset with detector high and side green
      for (int i = 0; i < 4; i++) begin
         step(1);
         check_outs("in_reset", 4'd0, 1'b0, 1'b0);
         check("in_reset_pulse", bus.arrival_pulse, 1'b0);
      end
      rst_n = 1'b1;
      drive(1'b0, MAIN_GREEN, 1'b0);
      step(1);
      check_outs("post_reset", 4'd0, 1'b0, 1'b0);
      step(7);
      check_outs("post_reset_idle", 4'd0, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         drive(vecs[i].raw, vecs[i].light, vecs[i].arrive);
         step(vecs[i].hold);
         check_outs(vecs[i].name, vecs[i].exp_pend, vecs[i].exp_sensor, 1'b0);
      end

      // bounce: 3-sample highs never reach the debounce threshold
      drive(1'b0, MAIN_GREEN, 1'b0);
      for (int r = 0; r < 4; r++) begin
         bus.raw_det = 1'b1;
         step(3);
         bus.raw_det = 1'b0;
         step(2);
      end
      step(8);
      check_outs("bounce", 4'd0, 1'b0, 1'b0);
      check("bounce_state", bus.deb_state, LOW);

      // simultaneous arrival and retirement at pending_count = 2
      for (int r = 0; r < 2; r++) begin
         drive(1'b1, MAIN_GREEN, 1'b1);
         step(8);
         drive(1'b0, MAIN_GREEN, 1'b0);
         step(8);
      end
      check("simul_setup_pending", bus.pending_count, 2);
      drive(1'b0, SIDE_GREEN, 1'b0);
      step(2);
      drive(1'b1, SIDE_GREEN, 1'b1);
      step(5);
      check("simul_before_pending", bus.pending_count, 2);
      step(1);
      check("simul_edge_pending", bus.pending_count, 2);
      drive(1'b0, SIDE_GREEN, 1'b0);
      step(8);
      check("simul_after_pending", bus.pending_count, 1);
      step(8);
      check_outs("simul_drained", 4'd0, 1'b0, 1'b0);

      // saturation: 20 arrivals into a 4-bit counter
      base = n_pulses;
      for (int r = 0; r < 20; r++) begin
         drive(1'b1, MAIN_GREEN, 1'b1);
         step(7);
         drive(1'b0, MAIN_GREEN, 1'b0);
         step(7);
      end
      check("sat_pulse_count", n_pulses - base, 20);
      check_outs("sat", 4'd15, 1'b1, 1'b0);
      drive(1'b0, SIDE_GREEN, 1'b0);
      step(15 * SERVE - 1);
      check_outs("sat_drain_last", 4'd1, 1'b1, 1'b0);
      step(1);
      check_outs("sat_drained", 4'd0, 1'b0, 1'b0);

      // reset in the middle of a debounce window
      drive(1'b1, MAIN_GREEN, 1'b0);
      step(4);
      rst_n = 1'b0;
      bus.raw_det = 1'b0;
      step(2);
      check_outs("mid_reset", 4'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step(10);
      check_outs("mid_reset_after", 4'd0, 1'b0, 1'b0);
      check("mid_reset_state", bus.deb_state, LOW);

      // stuck detector
      drive(1'b1, MAIN_GREEN, 1'b1);
      step(DEB + 2 + STUCK - 1);
      check_outs("stuck_before", 4'd1, 1'b1, 1'b0);
      step(1);
      check_outs("stuck_flag", 4'd1, 1'b1, 1'b1);
      drive(1'b1, SIDE_GREEN, 1'b0);
      step(SERVE);
      check_outs("stuck_drained", 4'd0, 1'b1, 1'b1);
      step(31);
      check_outs("stuck_300", 4'd0, 1'b1, 1'b1);
      drive(1'b0, MAIN_GREEN, 1'b0);
      step(DEB + 1);
      check_outs("stuck_fall_pending", 4'd0, 1'b1, 1'b1);
      step(1);
      check_outs("stuck_cleared", 4'd0, 1'b0, 1'b0);
      check("stuck_cleared_state", bus.deb_state, LOW);

      step(10);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
